// File: rtl/ibex_async_pkg.sv
// ibex_async_pkg
//   Shared definitions for the asynchronous instruction-fetch bridge:
//   bridge FSM state encoding, timeout counter width and a saturating
//   increment helper used by the WAIT timer.
package ibex_async_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK_HI = 3'd3,
    ST_ACK_LO = 3'd4
  } bridge_state_e;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : (v + 16'd1);
  endfunction

endpackage

// File: rtl/async_sync.sv
// async_sync
//   Multi-flop synchronizer for a single-bit level crossing into clk_i.
//   All stages clear asynchronously so a reset never leaves a stale
//   request level in the chain.
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input level
//   q_o     synchronized level, STAGES edges after d_i changes
module async_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ins_mem_bridge.sv
// ins_mem_bridge
//   Converts one 4-phase req/ack handshake from the instruction-fetch
//   controller into exactly one clocked memory transaction
//   (req/gnt address phase, rvalid response phase), with a response
//   timeout and a sticky protocol-violation flag.
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   req_i, addr_i         4-phase request (async) and bundled address
//   ack_o, rdata_o, err_o 4-phase acknowledge with response payload
//   instr_req_o/addr_o    memory request channel
//   instr_gnt_i           memory grant
//   instr_rvalid_i/rdata_i/err_i  memory response channel
//   proto_err_o           sticky protocol-violation flag
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for synchronized request rise
// ST_REQ    | instr_req_o high, waiting for grant (no timeout)
// ST_WAIT   | granted, waiting for rvalid or response timeout
// ST_ACK_HI | ack_o high with payload held, waiting for request fall
// ST_ACK_LO | ack_o low, one-cycle return to idle
module ins_mem_bridge
  import ibex_async_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        proto_err_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  bridge_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             req_s;
  logic             proto_viol;

  async_sync #(
    .STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (req_i),
    .q_o   (req_s)
  );

  // Terminal count is detected on the incremented value so the error
  // completion lands on the TIMEOUT-th WAIT edge.
  assign cnt_inc = sat_inc(cnt, TIMEOUT_C);

  assign proto_viol = (instr_rvalid_i && (state != ST_WAIT)) ||
                      (instr_gnt_i && (state != ST_REQ)) ||
                      (!req_s && ((state == ST_REQ) || (state == ST_WAIT)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      instr_req_o  <= 1'b0;
      instr_addr_o <= '0;
      ack_o        <= 1'b0;
      rdata_o      <= '0;
      err_o        <= 1'b0;
      proto_err_o  <= 1'b0;
    end else begin
      if (proto_viol) begin
        proto_err_o <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (req_s) begin
            instr_addr_o <= addr_i;
            instr_req_o  <= 1'b1;
            cnt          <= '0;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (instr_gnt_i) begin
            instr_req_o <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // rvalid is checked first so it beats a coincident timeout.
          if (instr_rvalid_i) begin
            rdata_o <= instr_rdata_i;
            err_o   <= instr_err_i;
            ack_o   <= 1'b1;
            state   <= ST_ACK_HI;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              rdata_o <= '0;
              err_o   <= 1'b1;
              ack_o   <= 1'b1;
              state   <= ST_ACK_HI;
            end
          end
        end
        ST_ACK_HI: begin
          if (!req_s) begin
            ack_o <= 1'b0;
            state <= ST_ACK_LO;
          end
        end
        ST_ACK_LO: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_mem_bridge.sv
module tb_ins_mem_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main DUT (TIMEOUT 255)
  logic        req, gnt, rvalid, err_in;
  logic [31:0] addr, rdata_in;
  logic        ack, err_o_w, ireq, proto;
  logic [31:0] rdata_o_w, iaddr;

  // timeout DUT (TIMEOUT 4)
  logic        t_req, t_gnt, t_rvalid, t_err_in;
  logic [31:0] t_addr, t_rdata_in;
  logic        t_ack, t_err_o, t_ireq, t_proto;
  logic [31:0] t_rdata_o, t_iaddr;

  int total = 0;
  int bad   = 0;
  int txn_cnt = 0;

  ins_mem_bridge #(.SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr),
    .ack_o(ack), .rdata_o(rdata_o_w), .err_o(err_o_w),
    .instr_req_o(ireq), .instr_addr_o(iaddr), .instr_gnt_i(gnt),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata_in), .instr_err_i(err_in),
    .proto_err_o(proto)
  );

  ins_mem_bridge #(.SYNC_STAGES(2), .TIMEOUT(4)) dut_to (
    .clk_i(clk), .rst_ni(rst_n), .req_i(t_req), .addr_i(t_addr),
    .ack_o(t_ack), .rdata_o(t_rdata_o), .err_o(t_err_o),
    .instr_req_o(t_ireq), .instr_addr_o(t_iaddr), .instr_gnt_i(t_gnt),
    .instr_rvalid_i(t_rvalid), .instr_rdata_i(t_rdata_in), .instr_err_i(t_err_in),
    .proto_err_o(t_proto)
  );

  always @(posedge clk) if (ireq && gnt) txn_cnt <= txn_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one full handshake on the main DUT; returns observations.
  task automatic fetch(input logic [31:0] a, input int gd, input int rd,
                       input logic [31:0] d, input logic e,
                       output logic [31:0] maddr, output logic [31:0] rdo,
                       output logic erro, output logic acko, output bit ok);
    int n;
    ok = 1'b1;
    req = 1'b1; addr = a;
    n = 0;
    while (!ireq && n < 10) begin @(negedge clk); n++; end
    if (!ireq) ok = 1'b0;
    maddr = iaddr;
    repeat (gd) @(negedge clk);
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    repeat (rd) @(negedge clk);
    rvalid = 1'b1; rdata_in = d; err_in = e;
    @(negedge clk);
    rvalid = 1'b0; err_in = 1'b0;
    acko = ack; rdo = rdata_o_w; erro = err_o_w;
    req = 1'b0;
    n = 0;
    while (ack && n < 10) begin @(negedge clk); n++; end
    if (ack) ok = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 1'b1; addr = 32'h0000_0444;
    t_req = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL reset_ireq: got %b want 0", ireq); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
    total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    total++; if (rdata_o_w !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata_o_w); end
    total++; if (err_o_w !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err_o_w); end
    total++; if (proto !== 1'b0) begin bad++; $display("FAIL reset_proto: got %b want 0", proto); end
    total++; if (t_ireq !== 1'b0) begin bad++; $display("FAIL reset_t_ireq: got %b want 0", t_ireq); end
    req = 1'b0; t_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL reset_release_idle: got %b want 0", ireq); end
  endtask

  task automatic test_basic();
    int n;
    req = 1'b1; addr = 32'h0000_0080;
    repeat (2) @(negedge clk);
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL basic_ireq_edge2: got %b want 0", ireq); end
    @(negedge clk);
    total++; if (ireq !== 1'b1) begin bad++; $display("FAIL basic_ireq_edge3: got %b want 1", ireq); end
    total++; if (iaddr !== 32'h0000_0080) begin bad++; $display("FAIL basic_iaddr: got %h want 00000080", iaddr); end
    repeat (2) @(negedge clk);
    total++; if (ireq !== 1'b1) begin bad++; $display("FAIL basic_ireq_hold: got %b want 1", ireq); end
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL basic_ireq_after_gnt: got %b want 0", ireq); end
    rvalid = 1'b1; rdata_in = 32'h0000_0013; err_in = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    total++; if (ack !== 1'b1) begin bad++; $display("FAIL basic_ack: got %b want 1", ack); end
    total++; if (rdata_o_w !== 32'h0000_0013) begin bad++; $display("FAIL basic_rdata: got %h want 00000013", rdata_o_w); end
    total++; if (err_o_w !== 1'b0) begin bad++; $display("FAIL basic_err: got %b want 0", err_o_w); end
    req = 1'b0;
    n = 0;
    while (ack && n < 3) begin @(negedge clk); n++; end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL basic_ack_fall: got %b want 0 within 3 edges", ack); end
    @(negedge clk);
    total++; if (proto !== 1'b0) begin bad++; $display("FAIL basic_proto: got %b want 0", proto); end
  endtask

  task automatic test_err_response();
    logic [31:0] ma, rd; logic e, a; bit ok;
    fetch(32'h0000_0200, 1, 1, 32'hDEAD_BEEF, 1'b1, ma, rd, e, a, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL err_handshake: got %b want 1", ok); end
    total++; if (a !== 1'b1) begin bad++; $display("FAIL err_ack: got %b want 1", a); end
    total++; if (e !== 1'b1) begin bad++; $display("FAIL err_err: got %b want 1", e); end
    total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL err_rdata: got %h want deadbeef", rd); end
    total++; if (ma !== 32'h0000_0200) begin bad++; $display("FAIL err_addr: got %h want 00000200", ma); end
  endtask

  task automatic test_race();
    int n;
    t_req = 1'b1; t_addr = 32'h0000_0300;
    n = 0;
    while (!t_ireq && n < 10) begin @(negedge clk); n++; end
    total++; if (t_ireq !== 1'b1) begin bad++; $display("FAIL race_ireq: got %b want 1", t_ireq); end
    t_gnt = 1'b1; @(negedge clk); t_gnt = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (t_ack !== 1'b0) begin bad++; $display("FAIL race_ack_early: got %b want 0", t_ack); end
    t_rvalid = 1'b1; t_rdata_in = 32'hCAFE_0001; t_err_in = 1'b0;
    @(negedge clk);
    t_rvalid = 1'b0;
    total++; if (t_ack !== 1'b1) begin bad++; $display("FAIL race_ack: got %b want 1", t_ack); end
    total++; if (t_err_o !== 1'b0) begin bad++; $display("FAIL race_err: got %b want 0", t_err_o); end
    total++; if (t_rdata_o !== 32'hCAFE_0001) begin bad++; $display("FAIL race_rdata: got %h want cafe0001", t_rdata_o); end
    t_req = 1'b0;
    n = 0;
    while (t_ack && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    total++; if (t_proto !== 1'b0) begin bad++; $display("FAIL race_proto: got %b want 0", t_proto); end
  endtask

  task automatic test_timeout();
    int n;
    t_req = 1'b1; t_addr = 32'h0000_0400; t_rdata_in = 32'h1234_5678;
    n = 0;
    while (!t_ireq && n < 10) begin @(negedge clk); n++; end
    total++; if (t_ireq !== 1'b1) begin bad++; $display("FAIL tmo_ireq: got %b want 1", t_ireq); end
    t_gnt = 1'b1; @(negedge clk); t_gnt = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (t_ack !== 1'b0) begin bad++; $display("FAIL tmo_ack_edge3: got %b want 0", t_ack); end
    @(negedge clk);
    total++; if (t_ack !== 1'b1) begin bad++; $display("FAIL tmo_ack_edge4: got %b want 1", t_ack); end
    total++; if (t_err_o !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", t_err_o); end
    total++; if (t_rdata_o !== 32'h0) begin bad++; $display("FAIL tmo_rdata: got %h want 0", t_rdata_o); end
    total++; if (t_proto !== 1'b0) begin bad++; $display("FAIL tmo_proto_before: got %b want 0", t_proto); end
    t_rvalid = 1'b1; @(negedge clk); t_rvalid = 1'b0;
    total++; if (t_proto !== 1'b1) begin bad++; $display("FAIL tmo_late_rvalid_proto: got %b want 1", t_proto); end
    total++; if (t_rdata_o !== 32'h0) begin bad++; $display("FAIL tmo_late_rdata_held: got %h want 0", t_rdata_o); end
    t_req = 1'b0;
    n = 0;
    while (t_ack && n < 10) begin @(negedge clk); n++; end
    total++; if (t_ack !== 1'b0) begin bad++; $display("FAIL tmo_ack_fall: got %b want 0", t_ack); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int n;
    req = 1'b1; addr = 32'h0000_2000;
    n = 0;
    while (!ireq && n < 10) begin @(negedge clk); n++; end
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL rstw_ireq: got %b want 0", ireq); end
    total++; if (ack !== 1'b0) begin bad++; $display("FAIL rstw_ack: got %b want 0", ack); end
    total++; if (iaddr !== 32'h0) begin bad++; $display("FAIL rstw_iaddr: got %h want 0", iaddr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL rstw_ireq_edge2: got %b want 0", ireq); end
    @(negedge clk);
    total++; if (ireq !== 1'b1) begin bad++; $display("FAIL rstw_ireq_edge3: got %b want 1", ireq); end
    total++; if (iaddr !== 32'h0000_2000) begin bad++; $display("FAIL rstw_iaddr_new: got %h want 00002000", iaddr); end
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    rvalid = 1'b1; rdata_in = 32'h0000_0777; err_in = 1'b0;
    @(negedge clk);
    rvalid = 1'b0;
    total++; if (rdata_o_w !== 32'h0000_0777) begin bad++; $display("FAIL rstw_rdata: got %h want 00000777", rdata_o_w); end
    req = 1'b0;
    n = 0;
    while (ack && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    total++; if (proto !== 1'b0) begin bad++; $display("FAIL rstw_proto: got %b want 0", proto); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ma, rd; logic e, a; bit ok;
    int start_cnt, gd, rdl;
    start_cnt = txn_cnt;
    for (int i = 0; i < 8; i++) begin
      gd  = int'($urandom_range(0, 5));
      rdl = int'($urandom_range(0, 5));
      fetch(32'h0000_1000 + 32'(i * 4), gd, rdl, 32'hA000_0000 | 32'(i), 1'b0, ma, rd, e, a, ok);
      total++; if (ok !== 1'b1 || a !== 1'b1) begin bad++; $display("FAIL b2b_handshake[%0d]: ok=%b ack=%b want 1/1", i, ok, a); end
      total++; if (ma !== 32'h0000_1000 + 32'(i * 4)) begin bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, ma, 32'h0000_1000 + 32'(i * 4)); end
      total++; if (rd !== (32'hA000_0000 | 32'(i))) begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd, 32'hA000_0000 | 32'(i)); end
    end
    total++; if (txn_cnt - start_cnt !== 8) begin bad++; $display("FAIL b2b_txn_count: got %0d want 8", txn_cnt - start_cnt); end
    total++; if (proto !== 1'b0) begin bad++; $display("FAIL b2b_proto: got %b want 0", proto); end
  endtask

  task automatic test_proto_gnt();
    repeat (2) @(negedge clk);
    gnt = 1'b1; @(negedge clk); gnt = 1'b0;
    total++; if (proto !== 1'b1) begin bad++; $display("FAIL proto_gnt_idle: got %b want 1", proto); end
    total++; if (ireq !== 1'b0) begin bad++; $display("FAIL proto_gnt_ignored: got %b want 0", ireq); end
    repeat (2) @(negedge clk);
    total++; if (proto !== 1'b1) begin bad++; $display("FAIL proto_sticky: got %b want 1", proto); end
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b0; addr = '0; gnt = 1'b0; rvalid = 1'b0; rdata_in = '0; err_in = 1'b0;
    t_req = 1'b0; t_addr = '0; t_gnt = 1'b0; t_rvalid = 1'b0; t_rdata_in = '0; t_err_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_err_response();
    test_race();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_proto_gnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
